// File: rtl/keypad_scan_controller.sv
// 4x3 matrix keypad scanner. Rows are driven one-hot and advance on each scan
// tick. Columns are sampled only on ticks, and presses and releases are
// debounced with a run-length counter. A confirmed press produces a one-cycle
// key_valid strobe, plus a star/sharp strobe in the same cycle for those keys.
// Handshake: key_valid is a pure strobe with no ready. The consumer must
// capture key_code in the cycle key_valid is high. key_code holds its value
// until the next confirmation.
`timescale 1ns/1ps
module keypad_scan_controller #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       initialize,
  input  logic       col1,
  input  logic       col2,
  input  logic       col3,
  output logic       row1,
  output logic       row2,
  output logic       row3,
  output logic       row4,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       star_pulse,
  output logic       sharp_pulse,
  output logic [1:0] o_dbg_state
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_row;
  logic [1:0]       r_col;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_star;
  logic             r_sharp;

  logic             w_tick;
  logic             w_any;
  logic [1:0]       w_col_idx;
  logic [3:0]       w_row_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [3:0]       w_code;

  assign w_tick     = (r_div == DIV_MAX);
  assign w_any      = col1 | col2 | col3;
  assign w_row_next = {r_row[2:0], r_row[3]};
  assign w_cnt_next = r_cnt + CNT_W'(1);

  // Prioritised column index: col1 wins over col2, and col2 over col3. 0 means none.
  always_comb begin
    w_col_idx = 2'd0;
    if (col1)      w_col_idx = 2'd1;
    else if (col2) w_col_idx = 2'd2;
    else if (col3) w_col_idx = 2'd3;
  end

  // Key code for the frozen row and the currently prioritised column.
  always_comb begin
    w_code = 4'hF;
    case (r_row)
      4'b0001: w_code = {2'b00, w_col_idx};
      4'b0010: w_code = 4'd3 + {2'b00, w_col_idx};
      4'b0100: w_code = 4'd6 + {2'b00, w_col_idx};
      4'b1000: begin
        case (w_col_idx)
          2'd1:    w_code = 4'hA;
          2'd2:    w_code = 4'h0;
          2'd3:    w_code = 4'hB;
          default: w_code = 4'hF;
        endcase
      end
      default: w_code = 4'hF;
    endcase
  end

  // Free-running scan tick divider.
  always_ff @(posedge clk or posedge initialize) begin
    if (initialize)  r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DIV_W'(1);
  end

  // Scan/debounce FSM with registered row drive, key code and strobes.
  always_ff @(posedge clk or posedge initialize) begin
    if (initialize) begin
      r_state     <= S_SCAN;
      r_cnt       <= '0;
      r_row       <= 4'b0001;
      r_col       <= 2'd0;
      r_key_code  <= 4'hF;
      r_key_valid <= 1'b0;
      r_star      <= 1'b0;
      r_sharp     <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_star      <= 1'b0;
      r_sharp     <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (!w_any) begin
              r_row <= w_row_next;
            end else begin
              r_col <= w_col_idx;
              r_cnt <= CNT_W'(1);
              if (DEBOUNCE_CNT == 1) begin
                r_state     <= S_HELD;
                r_key_code  <= w_code;
                r_key_valid <= 1'b1;
                r_star      <= (w_code == 4'hA);
                r_sharp     <= (w_code == 4'hB);
              end else begin
                r_state <= S_DEBOUNCE;
              end
            end
          end
          S_DEBOUNCE: begin
            if (w_any && (w_col_idx == r_col)) begin
              r_cnt <= w_cnt_next;
              if (w_cnt_next == CNT_DONE) begin
                r_state     <= S_HELD;
                r_key_code  <= w_code;
                r_key_valid <= 1'b1;
                r_star      <= (w_code == 4'hA);
                r_sharp     <= (w_code == 4'hB);
              end
            end else begin
              r_state <= S_SCAN;
              r_row   <= w_row_next;
              r_cnt   <= '0;
            end
          end
          S_HELD: begin
            if (!w_any) begin
              if (DEBOUNCE_CNT == 1) begin
                r_state <= S_SCAN;
                r_row   <= w_row_next;
                r_cnt   <= '0;
              end else begin
                r_state <= S_RELEASE;
                r_cnt   <= CNT_W'(1);
              end
            end
          end
          S_RELEASE: begin
            if (!w_any) begin
              r_cnt <= w_cnt_next;
              if (w_cnt_next == CNT_DONE) begin
                r_state <= S_SCAN;
                r_row   <= w_row_next;
                r_cnt   <= '0;
              end
            end else begin
              // A column bounce during release is not a new press.
              r_state <= S_HELD;
            end
          end
          default: r_state <= S_SCAN;
        endcase
      end
    end
  end

  assign row1        = r_row[0];
  assign row2        = r_row[1];
  assign row3        = r_row[2];
  assign row4        = r_row[3];
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign star_pulse  = r_star;
  assign sharp_pulse = r_sharp;
  assign key_held    = (r_state == S_HELD) || (r_state == S_RELEASE);
  assign o_dbg_state = r_state;

endmodule

// File: doc/keypad_scan_controller.md
KEYPAD_SCAN_CONTROLLER -- requirements
Module: keypad_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, the number of clk cycles per scan tick; legal range >= 2.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4, the number of consecutive identical tick samples that confirm a press or a release; legal range >= 1.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port initialize, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 SHALL have ports col1, col2, col3, input, 1 bit each: keypad column sense lines, active-high, already synchronised.
REQ-006 SHALL have ports row1, row2, row3, row4, output, 1 bit each: row drive lines, one-hot, active-high.
REQ-007 SHALL have port key_code, output, 4 bits: last confirmed key.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle strobe on press confirmation.
REQ-009 SHALL have port key_held, output, 1 bit: high while a confirmed key is still pressed.
REQ-010 SHALL have ports star_pulse and sharp_pulse, output, 1 bit each: one-cycle strobes for the * key and the # key.

Function
REQ-011 SHALL run a tick divider counting 0..SCAN_DIV-1 and wrapping to 0; tick is true in the cycle the count equals SCAN_DIV-1; the counter is $clog2(SCAN_DIV) bits wide.
REQ-012 SHALL hold exactly one row output high at all times after reset.
REQ-013 SHALL implement four states: SCAN, DEBOUNCE, HELD, RELEASE. Columns are sampled only on tick cycles.
REQ-014 In SCAN, on a tick with all columns low, SHALL advance the row row1 -> row2 -> row3 -> row4 -> row1.
REQ-015 In SCAN, on a tick with any column high, SHALL freeze the row, latch the column index (priority col1 > col2 > col3), set the stability count to 1 and enter DEBOUNCE.
REQ-016 In DEBOUNCE, on each tick where the prioritised column index still matches, SHALL increment the count; when the count reaches DEBOUNCE_CNT, SHALL enter HELD.
REQ-017 With DEBOUNCE_CNT = 1, SHALL go from SCAN directly to HELD on the detecting tick.
REQ-018 In DEBOUNCE, on a tick with a mismatch or all columns low, SHALL return to SCAN, advance to the next row and emit no strobe.
REQ-019 On entry to HELD, SHALL register key_code and pulse key_valid high for exactly the one clk cycle after the confirming tick.
REQ-020 SHALL encode key_code as follows: row r (1..3), column c gives 3*(r-1)+c; row4/col2 gives 4'h0; row4/col1 (*) gives 4'hA; row4/col3 (#) gives 4'hB.
REQ-021 SHALL hold key_code until the next confirmation.
REQ-022 SHALL assert star_pulse in the same cycle as key_valid when the code is 4'hA, and sharp_pulse in the same cycle when the code is 4'hB; otherwise both stay low.
REQ-023 SHALL drive key_held high in HELD and RELEASE and low in all other states.
REQ-024 In HELD, on a tick with all columns low, SHALL enter RELEASE with count 1; any column high keeps HELD.
REQ-025 In RELEASE, on a tick with all columns low, SHALL increment the count; at DEBOUNCE_CNT it SHALL return to SCAN, advance the row and drop key_held.
REQ-026 In RELEASE, on a tick with any column high, SHALL return to HELD with no new key_valid (bounce is not a new press).
REQ-027 SHALL ignore a second key pressed while in HELD or RELEASE; no strobe is emitted until a release is confirmed.
REQ-028 SHALL keep rows frozen in DEBOUNCE, HELD and RELEASE.
REQ-029 SHALL ignore column changes between ticks.

Reset
REQ-030 While initialize is high, SHALL force: state SCAN, divider 0, count 0, row1 high with the other rows low, key_code 4'hF, and key_valid, key_held, star_pulse, sharp_pulse all low.
REQ-031 SHALL, on an initialize assertion mid-DEBOUNCE or mid-HELD, abort immediately with no strobe; after deassertion, scanning restarts at row1.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-032 SHALL cover idle: no columns high for 40 cycles -> rows rotate every 4 cycles 1,2,3,4,1..., and key_valid never asserts.
REQ-033 SHALL cover a clean press: col3 held high while row2 is driven -> key_valid asserts one cycle after the 3rd matching tick, key_code=4'h6, row2 stays frozen, key_held=1.
REQ-034 SHALL cover the star key: col1 high during row4 -> key_code=4'hA, and star_pulse and key_valid are high in the same single cycle with sharp_pulse=0.
REQ-035 SHALL cover bounce: col1 high on row1 for 2 ticks, then low -> no key_valid, and scanning resumes at row2.
REQ-036 SHALL cover release bounce: after a confirmed '0', columns go low 1 tick, high 1 tick, then low 3 ticks -> exactly one key_valid in total, and key_held falls after the 3rd low tick.
REQ-037 SHALL cover reset mid-debounce: initialize pulsed during DEBOUNCE -> key_code=4'hF, row1 high, and no strobes.
